fetch_2ph_bridge: RTL
=====================

Name: fetch_2ph_bridge

Overview:
Clocked front end that streams program words out of the synchronous code SSRAM into the input of the mousetrap pipeline. On a start pulse it reads a block of consecutive words from a single-cycle-latency SRAM port and buffers them in a small FIFO. It presents each word to the asynchronous pipeline with a 2-phase (transition-signalled) bundled-data req/ack handshake. The incoming ack is synchronized, and a configurable bundling delay holds data stable before every req transition.

Parameters:
ADDR_WIDTH, 12, word address width (16 KB code RAM / 4 bytes per word)
DATA_WIDTH, 32, word width
FIFO_DEPTH, 4, buffer entries; power of two, >= 2
SYNC_STAGES, 2, flip-flops in the ack_in synchronizer; >= 2
SETUP_CYCLES, 1, clock cycles data_out is stable before req_out toggles; >= 1

Ports:
clk  in  1  system clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a transfer (ignored while busy)
base_addr  in  ADDR_WIDTH  first word address, sampled with start
word_count  in  ADDR_WIDTH+1  words to transfer, sampled with start
busy  out  1  transfer in progress
done  out  1  one-cycle pulse when the last word is acknowledged
mem_cs  out  1  SRAM read strobe
mem_addr  out  ADDR_WIDTH  SRAM word address
mem_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after mem_cs
req_out  out  1  2-phase request to pipeline; each toggle = one token
data_out  out  DATA_WIDTH  bundled data to pipeline
ack_in  in  1  2-phase acknowledge from pipeline, asynchronous to clk

Behaviour:
- Reset (async assert, sync release): busy=0, done=0, mem_cs=0, mem_addr=0, req_out=0, data_out=0. FIFO empties, synchronizer clears to 0, both FSMs go idle. Reset mid-transfer abandons the transfer; no done pulse follows.
- Fetch FSM: F_IDLE -> F_READ -> F_FLUSH -> F_IDLE.
  - F_IDLE: start=1 with word_count>0 latches base_addr and count, sets busy=1 next cycle, enters F_READ.
  - start=1 with word_count=0: done pulses the next cycle, busy stays 0, no memory access.
  - F_READ: mem_cs=1 only when (fifo_count + reads_in_flight) < FIFO_DEPTH. Each issued read increments mem_addr modulo 2^ADDR_WIDTH; 0xFFF wraps to 0x000. mem_rdata is written to the FIFO the cycle after mem_cs. After the last read is issued, go to F_FLUSH.
  - F_FLUSH: wait until all tokens are acknowledged, pulse done, clear busy in the same cycle, return to F_IDLE.
- Emit FSM: E_IDLE -> E_SETUP -> E_WAIT.
  - E_IDLE: FIFO not empty -> load head into data_out, pop, enter E_SETUP.
  - E_SETUP: count SETUP_CYCLES cycles, then toggle req_out and enter E_WAIT. data_out must not change from load until the matching ack.
  - E_WAIT: when ack_sync == req_out, the token is accepted and the remaining-token count decrements. If the FIFO is not empty, load the next word and enter E_SETUP in the same cycle; otherwise go to E_IDLE.
- ack_in passes through SYNC_STAGES flops before use. Ack-to-detection latency is SYNC_STAGES cycles.
- Simultaneous FIFO write and pop in one cycle is legal; count is unchanged. The FIFO never overflows because reads are gated by credit.
- start while busy=1 is ignored; latched base and count are unaffected.
- A spurious ack toggle while in E_IDLE or E_SETUP has no defined meaning. Flag it with a simulation-only assertion and do not alter state.
- Minimum per-token period = 1 + SETUP_CYCLES + SYNC_STAGES cycles plus pipeline ack delay.

Test Plan:
- Basic: SRAM[i]=0xA0000000+i, base=0x010, count=3, ack_in = req_out delayed 30 ns -> data_out 0xA0000010, 0xA0000011, 0xA0000012 in order; req_out toggles 3 times, ending at 1; single done pulse; busy low afterwards.
- Bundling: check every req_out edge -> data_out was stable for >= SETUP_CYCLES full clocks before the edge and unchanged until ack_sync matches.
- Backpressure: count=10, ack held off for 2 µs after first req -> exactly FIFO_DEPTH+1 words read (4 buffered + 1 on data_out), mem_cs stays low until acks resume, then all 10 words are delivered with no loss or duplication.
- Wrap and zero: base=0xFFE, count=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001. Then count=0 -> done one cycle after start, no mem_cs.
- Reset mid-transfer: rstn low after 2 of 8 tokens -> all outputs zero immediately, no done. A new start with base=0 and count=2 then delivers SRAM[0] and SRAM[1] correctly.
- Start ignored while busy: second start pulse with different base_addr during a transfer -> the first transfer completes unchanged and only one done pulse occurs.

Source files
------------

// File: rtl/fetch_2ph_bridge_if.sv
// ---------------------------------------------------------------------------
// fetch_2ph_bridge_if
//   Bundles the bridge's command, SRAM and 2-phase pipeline signals.
//
//   Command : start, base_addr, word_count -> bridge; busy, done <- bridge
//   SRAM    : mem_cs, mem_addr <- bridge; mem_rdata -> bridge
//   Pipeline: req_out, data_out <- bridge; ack_in -> bridge
//   Debug   : dbg_fetch_state, dbg_emit_state <- bridge (raw FSM encodings)
//
//   modport slave  : the bridge itself
//   modport master : whatever drives the bridge (controller, SRAM, pipeline)
// ---------------------------------------------------------------------------
interface fetch_2ph_bridge_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   word_count;
    logic                  busy;
    logic                  done;
    logic                  mem_cs;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  req_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  ack_in;
    logic [1:0]            dbg_fetch_state;
    logic [1:0]            dbg_emit_state;

    modport slave (
        input  start, base_addr, word_count, mem_rdata, ack_in,
        output busy, done, mem_cs, mem_addr, req_out, data_out,
        output dbg_fetch_state, dbg_emit_state
    );

    modport master (
        output start, base_addr, word_count, mem_rdata, ack_in,
        input  busy, done, mem_cs, mem_addr, req_out, data_out,
        input  dbg_fetch_state, dbg_emit_state
    );
endinterface

// File: rtl/fetch_2ph_bridge.sv
// ---------------------------------------------------------------------------
// fetch_2ph_bridge
//   Streams a block of consecutive words from a single-cycle-latency code
//   SSRAM into an asynchronous pipeline using a 2-phase bundled-data
//   req/ack handshake.
//
// Ports:
//   clk   - system clock, all state on rising edge
//   rstn  - asynchronous active-low reset
//   bus   - fetch_2ph_bridge_if.slave (command, SRAM, pipeline, debug)
//
// Handshakes:
//   start is a one-cycle pulse sampled only while idle (busy=0); base_addr
//   and word_count are captured on that cycle. An SRAM read is issued in any
//   cycle with mem_cs=1 and its data is taken from mem_rdata on the next
//   cycle, unconditionally. Towards the pipeline, each req_out transition
//   offers one token on data_out; the token is accepted once the
//   synchronized ack_in equals req_out, and data_out is held from its load
//   until that acceptance.
// ---------------------------------------------------------------------------
module fetch_2ph_bridge #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int SETUP_CYCLES = 1
) (
    input logic               clk,
    input logic               rstn,
    fetch_2ph_bridge_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SET_W = $clog2(SETUP_CYCLES + 1);

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_READ  = 2'd1,
        F_FLUSH = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        E_IDLE  = 2'd0,
        E_SETUP = 2'd1,
        E_WAIT  = 2'd2
    } emit_state_t;

    fetch_state_t          r_fstate;
    fetch_state_t          w_fstate_nxt;
    emit_state_t           r_estate;
    emit_state_t           w_estate_nxt;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_reads_left;
    logic [ADDR_WIDTH:0]   r_tokens_left;
    logic                  r_inflight;
    logic                  r_done;

    logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W:0]        r_wr_ptr;
    logic [PTR_W:0]        r_rd_ptr;
    logic [PTR_W:0]        w_fifo_count;
    logic                  w_fifo_empty;
    logic [DATA_WIDTH-1:0] w_fifo_head;
    logic [PTR_W+1:0]      w_credit_used;
    logic                  w_credit_ok;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_ack_sync;

    logic                  r_req;
    logic [DATA_WIDTH-1:0] r_data;
    logic [SET_W-1:0]      r_setup_cnt;

    logic w_mem_cs;
    logic w_start_ok;
    logic w_start_zero;
    logic w_flush_done;
    logic w_load;
    logic w_toggle;
    logic w_accept;

    // -----------------------------------------------------------------------
    // FIFO bookkeeping. The extra pointer bit separates full from empty.
    // -----------------------------------------------------------------------
    assign w_fifo_count = r_wr_ptr - r_rd_ptr;
    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_head  = r_fifo[r_rd_ptr[PTR_W-1:0]];

    // A read in flight already owns a slot, so credit counts it as occupied.
    assign w_credit_used = {1'b0, w_fifo_count} + {{(PTR_W+1){1'b0}}, r_inflight};
    assign w_credit_ok   = (w_credit_used < (PTR_W+2)'(FIFO_DEPTH));

    // -----------------------------------------------------------------------
    // Fetch FSM
    // -----------------------------------------------------------------------
    always_comb begin
        w_fstate_nxt = r_fstate;
        w_mem_cs     = 1'b0;
        w_start_ok   = 1'b0;
        w_start_zero = 1'b0;
        w_flush_done = 1'b0;
        case (r_fstate)
            F_IDLE: begin
                if (bus.start) begin
                    if (bus.word_count != '0) begin
                        w_start_ok   = 1'b1;
                        w_fstate_nxt = F_READ;
                    end else begin
                        w_start_zero = 1'b1;
                    end
                end
            end
            F_READ: begin
                w_mem_cs = w_credit_ok;
                if (w_credit_ok && (r_reads_left == (ADDR_WIDTH+1)'(1))) begin
                    w_fstate_nxt = F_FLUSH;
                end
            end
            F_FLUSH: begin
                if (r_tokens_left == '0) begin
                    w_flush_done = 1'b1;
                    w_fstate_nxt = F_IDLE;
                end
            end
            default: w_fstate_nxt = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fstate      <= F_IDLE;
            r_addr        <= '0;
            r_reads_left  <= '0;
            r_tokens_left <= '0;
            r_inflight    <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_fstate   <= w_fstate_nxt;
            r_done     <= w_start_zero | w_flush_done;
            r_inflight <= w_mem_cs;
            if (w_start_ok) begin
                r_addr       <= bus.base_addr;
                r_reads_left <= bus.word_count;
            end else if (w_mem_cs) begin
                r_addr       <= r_addr + ADDR_WIDTH'(1);
                r_reads_left <= r_reads_left - (ADDR_WIDTH+1)'(1);
            end
            if (w_start_ok) begin
                r_tokens_left <= bus.word_count;
            end else if (w_accept) begin
                r_tokens_left <= r_tokens_left - (ADDR_WIDTH+1)'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage: written with the SRAM word one cycle after each read.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (r_inflight) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_load)     r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (r_inflight) r_fifo[r_wr_ptr[PTR_W-1:0]] <= bus.mem_rdata;
    end

    // -----------------------------------------------------------------------
    // ack_in synchronizer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], bus.ack_in};
    end

    assign w_ack_sync = r_sync[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Emit FSM
    // -----------------------------------------------------------------------
    always_comb begin
        w_estate_nxt = r_estate;
        w_load       = 1'b0;
        w_toggle     = 1'b0;
        w_accept     = 1'b0;
        case (r_estate)
            E_IDLE: begin
                if (!w_fifo_empty) begin
                    w_load       = 1'b1;
                    w_estate_nxt = E_SETUP;
                end
            end
            E_SETUP: begin
                if (r_setup_cnt == SET_W'(SETUP_CYCLES - 1)) begin
                    w_toggle     = 1'b1;
                    w_estate_nxt = E_WAIT;
                end
            end
            E_WAIT: begin
                // 2-phase: ack has caught up with req once they are equal.
                if (w_ack_sync == r_req) begin
                    w_accept = 1'b1;
                    if (!w_fifo_empty) begin
                        w_load       = 1'b1;
                        w_estate_nxt = E_SETUP;
                    end else begin
                        w_estate_nxt = E_IDLE;
                    end
                end
            end
            default: w_estate_nxt = E_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_estate    <= E_IDLE;
            r_req       <= 1'b0;
            r_data      <= '0;
            r_setup_cnt <= '0;
        end else begin
            r_estate <= w_estate_nxt;
            if (w_load) begin
                r_data      <= w_fifo_head;
                r_setup_cnt <= '0;
            end else if (r_estate == E_SETUP) begin
                r_setup_cnt <= r_setup_cnt + SET_W'(1);
            end
            if (w_toggle) r_req <= ~r_req;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.busy            = (r_fstate != F_IDLE);
    assign bus.done            = r_done;
    assign bus.mem_cs          = w_mem_cs;
    assign bus.mem_addr        = r_addr;
    assign bus.req_out         = r_req;
    assign bus.data_out        = r_data;
    assign bus.dbg_fetch_state = r_fstate;
    assign bus.dbg_emit_state  = r_estate;

`ifndef SYNTHESIS
    // Outside E_WAIT no token is outstanding, so ack must already match req;
    // a toggle here is a protocol error on the pipeline side and is ignored.
    a_no_spurious_ack: assert property (
        @(posedge clk) disable iff (!rstn)
        (r_estate != E_WAIT) |-> (w_ack_sync == r_req)
    ) else $error("spurious ack_in toggle outside E_WAIT");
`endif

endmodule
